muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: RISC-V M-extension style multiply/divide unit.
// Multiplies finish in one cycle. Divides use a restoring radix-2 loop
// that produces one quotient bit per cycle. Divide-by-zero and signed
// overflow bypass the loop and complete in one cycle.
//
// state  | meaning
// IDLE   | ready for a request (in_ready=1)
// DIV    | restoring divide in progress, cnt_q = quotient bit index
// DONE   | result held on the outputs until out_ready
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             div_by_zero
);
    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [XLEN-1:0]  result_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             want_rem_q;
    logic             dbz_q;
    logic [TAG_W-1:0] tag_q;

    logic             is_div;
    logic             sgn_div;
    logic             want_rem;
    logic             b_zero;
    logic             sgn_ovf;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic [XLEN-1:0]  fast_res;
    logic [XLEN-1:0]  mul_res;
    logic             sgn_a_mul;
    logic             sgn_b_mul;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;

    logic [XLEN:0]    trial;
    logic [XLEN:0]    diff;
    logic [XLEN-1:0]  rem_d;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  div_res;

    // Decode the incoming request: multiply result, divide operand magnitudes and one-cycle divide cases.
    always_comb begin
        is_div    = op[2];
        sgn_div   = ~op[0];
        want_rem  = op[1];
        b_zero    = (b == '0);
        sgn_ovf   = sgn_div && (a == MOST_NEG) && (b == '1);
        a_neg     = sgn_div & a[XLEN-1];
        b_neg     = sgn_div & b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        // MULHU treats a as unsigned; only MULH treats b as signed. MUL only uses the low half.
        sgn_a_mul = (op[1:0] != 2'b11);
        sgn_b_mul = (op[1:0] == 2'b01);
        a_ext     = {{XLEN{sgn_a_mul & a[XLEN-1]}}, a};
        b_ext     = {{XLEN{sgn_b_mul & b[XLEN-1]}}, b};
        prod      = a_ext * b_ext;
        mul_res   = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        if (b_zero) begin
            fast_res = want_rem ? a : '1;
        end else begin
            fast_res = want_rem ? '0 : a;
        end
    end

    // One restoring-division step plus the sign correction applied on the final step.
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]};
        diff  = trial - {1'b0, dvsr_q};
        if (diff[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        quo_fix = neg_quo_q ? -quo_d : quo_d;
        rem_fix = neg_rem_q ? -rem_d : rem_d;
        div_res = want_rem_q ? rem_fix : quo_fix;
    end

    // Control FSM with registered result, tag and divide-by-zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            result_q   <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
            dbz_q      <= 1'b0;
            tag_q      <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        tag_q <= tag_in;
                        cnt_q <= '0;
                        if (!is_div) begin
                            result_q <= mul_res;
                            dbz_q    <= 1'b0;
                            state_q  <= S_DONE;
                        end else if (b_zero || sgn_ovf) begin
                            result_q <= fast_res;
                            dbz_q    <= b_zero;
                            state_q  <= S_DONE;
                        end else begin
                            rem_q      <= '0;
                            quo_q      <= a_mag;
                            dvsr_q     <= b_mag;
                            neg_quo_q  <= a_neg ^ b_neg;
                            neg_rem_q  <= a_neg;
                            want_rem_q <= want_rem;
                            state_q    <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == CNT_LAST) begin
                        result_q <= div_res;
                        dbz_q    <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign result      = result_q;
    assign tag_out     = tag_q;
    assign div_by_zero = dbz_q;

endmodule
